// File: rtl/cp0_unit.sv
// MIPS-style coprocessor-0 block: Count/Compare timer, Status, Cause, EPC,
// external interrupt synchronisation/edge latching and a registered interrupt request.
module cp0_unit #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ext_int,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
   output logic [31:0] rdata,
   input  logic        exc_enter,
   input  logic [4:0]  exc_code,
   input  logic [31:0] epc_in,
   input  logic        eret,
   output logic        int_req,
   output logic [31:0] epc_out,
   output logic        exl,
   output logic [31:0] handler_addr
);

   localparam logic [4:0]  REG_COUNT   = 5'd9;
   localparam logic [4:0]  REG_COMPARE = 5'd11;
   localparam logic [4:0]  REG_STATUS  = 5'd12;
   localparam logic [4:0]  REG_CAUSE   = 5'd13;
   localparam logic [4:0]  REG_EPC     = 5'd14;
   localparam logic [31:0] STATUS_MASK = 32'h0000_8703;
   localparam logic [31:0] IP_MASK     = 32'h0000_8700;

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic [31:0] status_q, status_d;
   logic [31:0] epc_q, epc_d;
   logic        ip7_q, ip7_d;
   logic        ip2_q, ip2_d;
   logic [1:0]  ip_sw_q, ip_sw_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic        ext_prev_q, ext_prev_d;
   logic        int_req_q, int_req_d;

   logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   logic        ext_rise;
   logic [31:0] cause_val;

   assign wr_count   = we && (waddr == REG_COUNT);
   assign wr_compare = we && (waddr == REG_COMPARE);
   assign wr_status  = we && (waddr == REG_STATUS);
   assign wr_cause   = we && (waddr == REG_CAUSE);
   assign wr_epc     = we && (waddr == REG_EPC);
   assign ext_rise   = sync2_q && !ext_prev_q;
   assign cause_val  = {16'h0000, ip7_q, 4'h0, ip2_q, ip_sw_q, 1'b0, exc_code_q, 2'b00};

   always_comb begin
      sync1_d    = ext_int;
      sync2_d    = sync1_q;
      ext_prev_d = sync2_q;

      int_req_d  = ((cause_val & status_q & IP_MASK) != 32'h0) && status_q[0] && !status_q[1];

      count_d    = wr_count ? wdata : count_q + 32'd1;
      compare_d  = wr_compare ? wdata : compare_q;

      // A Compare write acknowledges the timer, even against a same-cycle match
      ip7_d = ip7_q;
      if (wr_compare)
         ip7_d = 1'b0;
      else if (count_q == compare_q)
         ip7_d = 1'b1;

      // A fresh edge must never be lost to a concurrent write-1-to-clear
      ip2_d   = ext_rise || (ip2_q && !(wr_cause && wdata[10]));
      ip_sw_d = wr_cause ? wdata[9:8] : ip_sw_q;

      exc_code_d = exc_code_q;
      if (exc_enter)
         exc_code_d = exc_code;
      else if (wr_cause)
         exc_code_d = wdata[6:2];

      status_d = wr_status ? (wdata & STATUS_MASK) : status_q;
      if (exc_enter)
         status_d[1] = 1'b1;
      else if (eret)
         status_d[1] = 1'b0;

      epc_d = epc_q;
      if (exc_enter)
         epc_d = epc_in & ~32'd3;
      else if (wr_epc)
         epc_d = wdata & ~32'd3;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q    <= 32'h0;
         compare_q  <= 32'hFFFF_FFFF;
         status_q   <= 32'h0;
         epc_q      <= 32'h0;
         ip7_q      <= 1'b0;
         ip2_q      <= 1'b0;
         ip_sw_q    <= 2'b00;
         exc_code_q <= 5'd0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         ext_prev_q <= 1'b0;
         int_req_q  <= 1'b0;
      end else begin
         count_q    <= count_d;
         compare_q  <= compare_d;
         status_q   <= status_d;
         epc_q      <= epc_d;
         ip7_q      <= ip7_d;
         ip2_q      <= ip2_d;
         ip_sw_q    <= ip_sw_d;
         exc_code_q <= exc_code_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         ext_prev_q <= ext_prev_d;
         int_req_q  <= int_req_d;
      end
   end

   always_comb begin
      rdata = 32'h0;
      case (raddr)
         REG_COUNT:   rdata = count_q;
         REG_COMPARE: rdata = compare_q;
         REG_STATUS:  rdata = status_q;
         REG_CAUSE:   rdata = cause_val;
         REG_EPC:     rdata = epc_q;
         default:     rdata = 32'h0;
      endcase
   end

   assign int_req      = int_req_q;
   assign epc_out      = epc_q;
   assign exl          = status_q[1];
   assign handler_addr = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed vector table, hand sequences for multi-cycle corners,
// and randomized traffic against a register-level reference model.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ext_int;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;
   logic        exc_enter;
   logic [4:0]  exc_code;
   logic [31:0] epc_in;
   logic        eret;
   logic        int_req;
   logic [31:0] epc_out;
   logic        exl;
   logic [31:0] handler_addr;

   cp0_unit dut (
      .clk(clk), .reset(reset), .ext_int(ext_int), .we(we), .waddr(waddr),
      .wdata(wdata), .raddr(raddr), .rdata(rdata), .exc_enter(exc_enter),
      .exc_code(exc_code), .epc_in(epc_in), .eret(eret), .int_req(int_req),
      .epc_out(epc_out), .exl(exl), .handler_addr(handler_addr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: architectural register contents
   logic [31:0] m_count, m_compare, m_status, m_epc;
   logic        m_ip7, m_ip2, m_int;
   logic [1:0]  m_ipsw;
   logic [4:0]  m_exc;
   bit          ext_hist[$];

   function automatic logic [31:0] m_cause();
      return {16'h0000, m_ip7, 4'h0, m_ip2, m_ipsw, 1'b0, m_exc, 2'b00};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd9:    return m_count;
         5'd11:   return m_compare;
         5'd12:   return m_status;
         5'd13:   return m_cause();
         5'd14:   return m_epc;
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_count = 32'h0; m_compare = 32'hFFFF_FFFF; m_status = 32'h0; m_epc = 32'h0;
      m_ip7 = 1'b0; m_ip2 = 1'b0; m_int = 1'b0; m_ipsw = 2'b00; m_exc = 5'd0;
      ext_hist = {1'b0, 1'b0, 1'b0, 1'b0};
   endtask

   task automatic model_edge();
      logic wr_cnt, wr_cmp, wr_st, wr_ca, wr_ep, rise, n_int;
      int   n;
      wr_cnt = we && waddr == 5'd9;
      wr_cmp = we && waddr == 5'd11;
      wr_st  = we && waddr == 5'd12;
      wr_ca  = we && waddr == 5'd13;
      wr_ep  = we && waddr == 5'd14;
      n_int  = ((m_cause() & m_status & 32'h0000_8700) != 0) && m_status[0] && !m_status[1];
      // IP2 sets two edges after the edge that first samples ext_int high
      ext_hist.push_back(ext_int);
      n    = ext_hist.size();
      rise = ext_hist[n-3] && !ext_hist[n-4];
      if (n > 8) void'(ext_hist.pop_front());

      if (wr_cmp) m_ip7 = 1'b0;
      else if (m_count == m_compare) m_ip7 = 1'b1;
      if (rise) m_ip2 = 1'b1;
      else if (wr_ca && wdata[10]) m_ip2 = 1'b0;
      if (wr_ca) m_ipsw = wdata[9:8];
      if (exc_enter) m_exc = exc_code;
      else if (wr_ca) m_exc = wdata[6:2];
      if (wr_st) m_status = wdata & 32'h0000_8703;
      if (exc_enter) m_status[1] = 1'b1;
      else if (eret) m_status[1] = 1'b0;
      if (exc_enter) m_epc = epc_in & ~32'd3;
      else if (wr_ep) m_epc = wdata & ~32'd3;
      m_count   = wr_cnt ? wdata : m_count + 32'd1;
      if (wr_cmp) m_compare = wdata;
      m_int = n_int;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_rdata", rdata, m_read(raddr));
      chk("model_epc", epc_out, m_epc);
      chk("model_exl", {31'b0, exl}, {31'b0, m_status[1]});
      chk("model_int", {31'b0, int_req}, {31'b0, m_int});
   endtask

   task automatic clear_in();
      we = 1'b0; exc_enter = 1'b0; eret = 1'b0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; waddr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  raddr;
      logic        exc_enter;
      logic [4:0]  exc_code;
      logic [31:0] epc_in;
      logic        eret;
      logic [31:0] exp_rdata;
      logic        exp_exl;
      logic        exp_int;
   } vec_t;

   function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic ee, input logic [4:0] ec,
                               input logic [31:0] ep, input logic er, input logic [31:0] xr,
                               input logic xe, input logic xi);
      vec_t v;
      v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exc_enter = ee;
      v.exc_code = ec; v.epc_in = ep; v.eret = er; v.exp_rdata = xr;
      v.exp_exl = xe; v.exp_int = xi;
      return v;
   endfunction

   vec_t vecs[16];

   initial begin
      //                 we waddr  wdata          raddr exc code epc_in      eret exp_rdata     exl int
      vecs[0]  = mk(1, 5'd12, 32'hFFFF_FFFF, 5'd12, 0, 5'd0, 32'h0,       0, 32'h0000_8703, 1, 0);
      vecs[1]  = mk(1, 5'd12, 32'h0000_0401, 5'd12, 0, 5'd0, 32'h0,       0, 32'h0000_0401, 0, 0);
      vecs[2]  = mk(1, 5'd13, 32'h0000_0300, 5'd13, 0, 5'd0, 32'h0,       0, 32'h0000_0300, 0, 0);
      vecs[3]  = mk(0, 5'd0,  32'h0,         5'd13, 0, 5'd0, 32'h0,       0, 32'h0000_0300, 0, 0);
      vecs[4]  = mk(1, 5'd12, 32'h0000_0301, 5'd12, 0, 5'd0, 32'h0,       0, 32'h0000_0301, 0, 0);
      vecs[5]  = mk(0, 5'd0,  32'h0,         5'd13, 0, 5'd0, 32'h0,       0, 32'h0000_0300, 0, 1);
      vecs[6]  = mk(0, 5'd0,  32'h0,         5'd14, 1, 5'd0, 32'h0000_1237, 0, 32'h0000_1234, 1, 1);
      vecs[7]  = mk(0, 5'd0,  32'h0,         5'd13, 0, 5'd0, 32'h0,       0, 32'h0000_0300, 1, 0);
      vecs[8]  = mk(0, 5'd0,  32'h0,         5'd13, 1, 5'd5, 32'h0000_2000, 1, 32'h0000_0314, 1, 0);
      vecs[9]  = mk(0, 5'd0,  32'h0,         5'd14, 0, 5'd0, 32'h0,       1, 32'h0000_2000, 0, 0);
      vecs[10] = mk(0, 5'd0,  32'h0,         5'd12, 0, 5'd0, 32'h0,       0, 32'h0000_0301, 0, 1);
      vecs[11] = mk(1, 5'd14, 32'h0000_0040, 5'd14, 1, 5'd3, 32'h0000_0088, 0, 32'h0000_0088, 1, 1);
      vecs[12] = mk(1, 5'd12, 32'h0000_0002, 5'd12, 0, 5'd0, 32'h0,       1, 32'h0000_0000, 0, 0);
      vecs[13] = mk(0, 5'd0,  32'h0,         5'd14, 0, 5'd0, 32'h0,       0, 32'h0000_0088, 0, 0);
      vecs[14] = mk(1, 5'd5,  32'hFFFF_FFFF, 5'd5,  0, 5'd0, 32'h0,       0, 32'h0000_0000, 0, 0);
      vecs[15] = mk(1, 5'd14, 32'hFFFF_FFFF, 5'd14, 0, 5'd0, 32'h0,       0, 32'hFFFF_FFFC, 0, 0);

      reset = 1'b1; ext_int = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0; raddr = 5'd11;
      exc_enter = 1'b0; exc_code = 5'd0; epc_in = 32'h0; eret = 1'b0;
      model_reset();

      // Reset state
      @(negedge clk);
      #1 chk("rst_compare", rdata, 32'hFFFF_FFFF);
      raddr = 5'd12; #1 chk("rst_status", rdata, 32'h0);
      raddr = 5'd13; #1 chk("rst_cause", rdata, 32'h0);
      raddr = 5'd9;  #1 chk("rst_count", rdata, 32'h0);
      chk("rst_epc", epc_out, 32'h0);
      chk("rst_exl", {31'b0, exl}, 32'h0);
      chk("rst_int", {31'b0, int_req}, 32'h0);
      chk("handler_addr", handler_addr, 32'h0000_0180);
      @(negedge clk);
      reset = 1'b0;

      // Directed vectors
      for (int i = 0; i < 16; i++) begin
         we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; raddr = vecs[i].raddr;
         exc_enter = vecs[i].exc_enter; exc_code = vecs[i].exc_code;
         epc_in = vecs[i].epc_in; eret = vecs[i].eret;
         step();
         chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_exl", i), {31'b0, exl}, {31'b0, vecs[i].exp_exl});
         chk($sformatf("vec%0d_int", i), {31'b0, int_req}, {31'b0, vecs[i].exp_int});
         clear_in();
      end

      // Count wrap
      raddr = 5'd9;
      write(5'd9, 32'hFFFF_FFFE);
      chk("cnt_load", rdata, 32'hFFFF_FFFE);
      step(); chk("cnt_ffff", rdata, 32'hFFFF_FFFF);
      step(); chk("cnt_wrap0", rdata, 32'h0);
      step(); chk("cnt_wrap1", rdata, 32'h1);

      // External interrupt edge latency and write-1-to-clear
      write(5'd13, 32'h0);
      write(5'd12, 32'h0000_0401);
      raddr = 5'd13;
      ext_int = 1'b1; step(); ext_int = 1'b0;
      chk("ip2_e0", {31'b0, rdata[10]}, 32'h0);
      step(); chk("ip2_e1", {31'b0, rdata[10]}, 32'h0);
      step(); chk("ip2_e2", {31'b0, rdata[10]}, 32'h1);
      chk("int_e2", {31'b0, int_req}, 32'h0);
      step(); chk("int_e3", {31'b0, int_req}, 32'h1);
      write(5'd13, 32'h0000_0400);
      chk("ip2_w1c", {31'b0, rdata[10]}, 32'h0);
      step(); chk("int_after_w1c", {31'b0, int_req}, 32'h0);
      ext_int = 1'b1; step(); ext_int = 1'b0;
      step();
      write(5'd13, 32'h0000_0400);
      chk("ip2_edge_beats_clear", {31'b0, rdata[10]}, 32'h1);
      write(5'd13, 32'h0000_0400);
      chk("ip2_clear", {31'b0, rdata[10]}, 32'h0);
      write(5'd12, 32'h0);
      ext_int = 1'b1; step(); ext_int = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("masked_ip2", {31'b0, rdata[10]}, 32'h1);
      chk("masked_int", {31'b0, int_req}, 32'h0);
      write(5'd13, 32'h0000_0400);

      // Timer compare
      write(5'd11, 32'd20);
      write(5'd9, 32'd10);
      write(5'd12, 32'h0000_8001);
      raddr = 5'd13;
      for (int k = 0; k < 9; k++) step();
      chk("ip7_before", {31'b0, rdata[15]}, 32'h0);
      step(); chk("ip7_set", {31'b0, rdata[15]}, 32'h1);
      chk("ip7_int_pre", {31'b0, int_req}, 32'h0);
      step(); chk("ip7_int", {31'b0, int_req}, 32'h1);
      write(5'd11, 32'd100);
      chk("ip7_clear", {31'b0, rdata[15]}, 32'h0);
      write(5'd9, 32'd99);
      step();
      write(5'd11, 32'd100);
      chk("ip7_clear_beats_match", {31'b0, rdata[15]}, 32'h0);
      step(); chk("ip7_no_late_match", {31'b0, rdata[15]}, 32'h0);

      // Asynchronous reset in the middle of an exception
      write(5'd12, 32'h0000_0401);
      ext_int = 1'b1; step(); ext_int = 1'b0;
      for (int k = 0; k < 3; k++) step();
      exc_enter = 1'b1; epc_in = 32'h0000_0500; exc_code = 5'd0;
      step(); clear_in();
      chk("pre_rst_exl", {31'b0, exl}, 32'h1);
      chk("pre_rst_int", {31'b0, int_req}, 32'h1);
      chk("pre_rst_ip2", {31'b0, rdata[10]}, 32'h1);
      #2 reset = 1'b1; model_reset();
      #1;
      chk("arst_exl", {31'b0, exl}, 32'h0);
      chk("arst_int", {31'b0, int_req}, 32'h0);
      chk("arst_epc", epc_out, 32'h0);
      chk("arst_cause", rdata, 32'h0);
      raddr = 5'd11; #1 chk("arst_compare", rdata, 32'hFFFF_FFFF);
      ext_int = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      raddr = 5'd13;
      step(); chk("rel_ip2_e1", {31'b0, rdata[10]}, 32'h0);
      step(); chk("rel_ip2_e2", {31'b0, rdata[10]}, 32'h0);
      step(); chk("rel_ip2_e3", {31'b0, rdata[10]}, 32'h1);
      ext_int = 1'b0;

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         we = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 5))
            0:       waddr = 5'd9;
            1:       waddr = 5'd11;
            2:       waddr = 5'd12;
            3:       waddr = 5'd13;
            4:       waddr = 5'd14;
            default: waddr = 5'($urandom_range(0, 31));
         endcase
         wdata = $urandom;
         if (waddr == 5'd9) wdata = m_compare - 32'($urandom_range(0, 6));
         if (waddr == 5'd11 && $urandom_range(0, 1) == 1) wdata = m_count + 32'($urandom_range(0, 6));
         if (waddr == 5'd12 && $urandom_range(0, 1) == 1) wdata[1] = 1'b0;
         case ($urandom_range(0, 5))
            0:       raddr = 5'd9;
            1:       raddr = 5'd11;
            2:       raddr = 5'd12;
            3:       raddr = 5'd13;
            4:       raddr = 5'd14;
            default: raddr = 5'($urandom_range(0, 31));
         endcase
         exc_enter = ($urandom_range(0, 15) == 0);
         exc_code  = 5'($urandom);
         epc_in    = $urandom;
         eret      = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 7) == 0) ext_int = ~ext_int;
         step();
      end
      clear_in();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 Parameter HANDLER_ADDR, default 32'h0000_0180: exception vector driven on handler_addr.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ext_int  input  1  raw external interrupt line, asynchronous to clk.
REQ-005 we  input  1  mtc0 write strobe.
REQ-006 waddr  input  5  CP0 register number written: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
REQ-007 wdata  input  32  mtc0 data.
REQ-008 raddr  input  5  CP0 register number read by mfc0.
REQ-009 rdata  output  32  combinational read of register raddr.
REQ-010 exc_enter  input  1  one-cycle pulse from controller on exception/interrupt entry.
REQ-011 exc_code  input  5  ExcCode captured on exc_enter (0 = interrupt).
REQ-012 epc_in  input  32  return address captured on exc_enter.
REQ-013 eret  input  1  one-cycle pulse on exception return.
REQ-014 int_req  output  1  registered interrupt request to controller INT input.
REQ-015 epc_out  output  32  current EPC value.
REQ-016 exl  output  1  current Status.EXL.
REQ-017 handler_addr  output  32  constant HANDLER_ADDR.

Function
REQ-018 Status: bits [15],[10],[8:9] IM, [1] EXL, [0] IE writable; all other bits read 0.
REQ-019 Cause: [15] IP7 timer, [10] IP2 external, [9:8] IP software (writable), [6:2] ExcCode; other bits read 0.
REQ-020 EPC: 32 bits, bits [1:0] always 0 on any write.
REQ-021 Reads of unimplemented register numbers return 0; writes to them are ignored.
REQ-022 ext_int passes a two-flop synchronizer then a previous-value flop; IP2 sets on synchronized rising edge: ext_int sampled high at edge E -> IP2 = 1 after edge E+2.
REQ-023 IP2 is edge-latched; cleared only by mtc0 to Cause with wdata[10] = 1 (write-1-to-clear); simultaneous new edge and clear -> IP2 stays 1.
REQ-024 int_req registered: after each edge equals (|(IP & IM) over bits 15,10,9,8) & IE & ~EXL evaluated on pre-edge values; ext_int edge at E -> int_req = 1 after edge E+3.
REQ-025 Count increments by 1 every cycle, wraps 32'hFFFF_FFFF -> 0; mtc0 to Count loads wdata with no increment that cycle.
REQ-026 IP7 sets at the edge where Count == Compare (pre-edge values); mtc0 to Compare loads wdata and clears IP7, clear winning over a same-cycle match.
REQ-027 exc_enter: EPC <= epc_in & ~3, ExcCode <= exc_code, EXL <= 1; IE and IP bits unchanged.
REQ-028 eret: EXL <= 0 next edge; epc_out continuously reflects EPC.
REQ-029 exc_enter and eret same cycle: exc_enter wins (EXL = 1).
REQ-030 exc_enter and mtc0 same cycle: exc_enter wins on EPC, ExcCode, EXL; write applied to all other writable fields.
REQ-031 mtc0 to Status and eret same cycle: eret wins on EXL.

Reset
REQ-032 On reset: Status, Cause, EPC, Count = 0; Compare = 32'hFFFF_FFFF; synchronizer and edge flops = 0; int_req = 0; exl = 0.
REQ-033 ext_int held high across reset release counts as a rising edge (IP2 sets 3 edges after release).
REQ-034 Reset asserted mid-exception clears EXL and pending bits immediately, without waiting for clk.

Verification
REQ-035 Status=32'h0401, pulse ext_int at edge 10 -> IP2 = 1 after edge 12, int_req = 1 after edge 13; with Status=0 int_req stays 0.
REQ-036 exc_enter with epc_in=32'h0000_1237, exc_code=0 -> EPC=32'h0000_1234, Cause[6:2]=0, exl=1, int_req=0 next edge; eret -> exl=0, int_req returns to 1 while IP2 set; write Cause 32'h400 -> IP2=0, int_req=0.
REQ-037 Write Compare=20, Count=10, Status=32'h8001 -> IP7=1 ten edges later, int_req one edge after; write Compare=100 -> IP7=0.
REQ-038 Write Count=32'hFFFF_FFFE -> reads FFFF_FFFF, then 0, then 1 on successive cycles.
REQ-039 Same-cycle exc_enter+eret -> exl=1; same-cycle exc_enter+mtc0 EPC=32'h40 -> EPC=epc_in; mtc0 to raddr 5 then read -> rdata=0.
REQ-040 Assert reset with EXL=1, IP2=1, int_req=1 between clock edges -> all outputs 0 immediately, Compare reads FFFF_FFFF.
